// File: rtl/ram_fifo_ctrl_if.sv
// Push/pop stream handshake bundle for ram_fifo_ctrl.
//   in_valid/in_data/in_ready    : upstream push, accepted when in_valid & in_ready
//   out_valid/out_data/out_ready : show-ahead head word, popped when out_valid & out_ready
// master: the producer/consumer side; slave: the FIFO controller side.
interface ram_fifo_ctrl_if #(
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller around an external RAM with RD_LAT-cycle read latency.
// Words are written straight into the RAM, read back once they are visible,
// and collected in a small show-ahead output buffer.
//   clk, rst         : clock, asynchronous active-high reset
//   stream (slave)   : push/pop handshake (in_*/out_*)
//   ram_we/waddr/din : RAM write port
//   ram_re/raddr     : RAM read request
//   ram_dout/perr    : RAM read data and parity flag, RD_LAT cycles after ram_re
//   count            : words accepted and not yet popped
//   perr_sticky      : set when a captured word carried a parity error
module ram_fifo_ctrl #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  ram_fifo_ctrl_if.slave    stream,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [DATA_W-1:0] ram_din,
  output logic [ADDR_W-1:0] ram_raddr,
  output logic              ram_re,
  input  logic [DATA_W-1:0] ram_dout,
  input  logic              ram_perr,
  output logic [ADDR_W:0]   count,
  output logic              perr_sticky
);
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int CNT_W  = ADDR_W + 1;
  localparam int BUF_N  = RD_LAT + 1;
  localparam int PTR_W  = $clog2(BUF_N);
  localparam int BCNT_W = 2;
  localparam int OCC_W  = 3;

  generate
    if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_rd_lat
      $error("ram_fifo_ctrl: RD_LAT must be 1 or 2");
    end
  endgenerate

  logic [ADDR_W-1:0] wptr, rptr;
  logic [CNT_W-1:0]  ram_cnt, avail, count_q;
  logic              full;
  logic [RD_LAT-1:0] vis_dly, infl;
  logic [DATA_W-1:0] buf_mem [BUF_N];
  logic [PTR_W-1:0]  bwp, brp;
  logic [BCNT_W-1:0] buf_cnt;
  logic              perr_q;

  logic              push, pop, rd_go, land, vis_out;
  logic [CNT_W-1:0]  ram_cnt_nxt, avail_nxt, count_nxt;
  logic [OCC_W-1:0]  infl_cnt, occ;

  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_N - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign push    = stream.in_valid & stream.in_ready;
  assign pop     = stream.out_valid & stream.out_ready;
  assign land    = infl[RD_LAT-1];
  assign vis_out = vis_dly[RD_LAT-1];

  assign stream.in_ready  = ~full & ~rst;
  assign stream.out_valid = (buf_cnt != '0);
  assign stream.out_data  = buf_mem[brp];

  assign ram_we      = push;
  assign ram_waddr   = wptr;
  assign ram_din     = stream.in_data;
  assign ram_re      = rd_go;
  assign ram_raddr   = rptr;
  assign count       = count_q;
  assign perr_sticky = perr_q;

  always_comb begin
    infl_cnt = '0;
    for (int unsigned i = 0; i < RD_LAT; i++) begin
      infl_cnt = infl_cnt + OCC_W'(infl[i]);
    end
    // Occupancy is taken after this cycle's pop so a read can issue every
    // cycle while the consumer drains; buffer + in-flight never exceeds BUF_N.
    occ = OCC_W'(buf_cnt) + infl_cnt - OCC_W'(pop);
    // A word leaving the visibility delay this cycle is readable right away.
    rd_go = ((avail != '0) || vis_out) && (occ < OCC_W'(BUF_N));
    ram_cnt_nxt = ram_cnt + CNT_W'(push) - CNT_W'(rd_go);
    avail_nxt   = avail + CNT_W'(vis_out) - CNT_W'(rd_go);
    count_nxt   = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr    <= '0;
      rptr    <= '0;
      ram_cnt <= '0;
      avail   <= '0;
      count_q <= '0;
      full    <= 1'b0;
      vis_dly <= '0;
      infl    <= '0;
      bwp     <= '0;
      brp     <= '0;
      buf_cnt <= '0;
      perr_q  <= 1'b0;
      for (int unsigned i = 0; i < BUF_N; i++) begin
        buf_mem[i] <= '0;
      end
    end else begin
      if (push)  wptr <= wptr + ADDR_W'(1);
      if (rd_go) rptr <= rptr + ADDR_W'(1);
      ram_cnt <= ram_cnt_nxt;
      full    <= (ram_cnt_nxt == CNT_W'(DEPTH));
      avail   <= avail_nxt;
      count_q <= count_nxt;
      vis_dly <= (vis_dly << 1) | RD_LAT'(push);
      infl    <= (infl << 1) | RD_LAT'(rd_go);
      if (land) begin
        buf_mem[bwp] <= ram_dout;
        bwp          <= bump(bwp);
        if (ram_perr) perr_q <= 1'b1;
      end
      if (pop) brp <= bump(brp);
      buf_cnt <= buf_cnt + BCNT_W'(land) - BCNT_W'(pop);
    end
  end
endmodule

// File: tb/tb_ram_fifo_ctrl.sv
module tb_ram_fifo_ctrl;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 32;
  localparam int RD_LAT = 2;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int MAXCNT = DEPTH + RD_LAT + 1;
  localparam int NVEC   = 17;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              ram_we, ram_re, ram_perr, perr_sticky;
  logic [ADDR_W-1:0] ram_waddr, ram_raddr;
  logic [DATA_W-1:0] ram_din, ram_dout;
  logic [ADDR_W:0]   count;

  ram_fifo_ctrl_if #(.DATA_W(DATA_W)) bus ();

  ram_fifo_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst), .stream(bus),
    .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_din(ram_din),
    .ram_raddr(ram_raddr), .ram_re(ram_re),
    .ram_dout(ram_dout), .ram_perr(ram_perr),
    .count(count), .perr_sticky(perr_sticky)
  );

  always #5 clk = ~clk;

  // RAM model: registered read with RD_LAT stages; parity error injected on
  // the perr_target-th read after reset (0 = never).
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_pipe [RD_LAT];
  logic [RD_LAT-1:0] perr_pipe;
  int rd_cnt;
  int perr_target = 0;

  always @(posedge clk) begin
    if (ram_we) mem[ram_waddr] <= ram_din;
    rd_pipe[0]   <= ram_re ? mem[ram_raddr] : 32'hBAD0_BAD0;
    perr_pipe[0] <= ram_re && (perr_target != 0) && (rd_cnt == perr_target - 1);
    for (int i = 1; i < RD_LAT; i++) begin
      rd_pipe[i]   <= rd_pipe[i-1];
      perr_pipe[i] <= perr_pipe[i-1];
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) rd_cnt <= 0;
    else if (ram_re) rd_cnt <= rd_cnt + 1;
  end

  assign ram_dout = rd_pipe[RD_LAT-1];
  assign ram_perr = perr_pipe[RD_LAT-1];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    check("rst in_ready", bus.in_ready, 0);
    check("rst out_valid", bus.out_valid, 0);
    check("rst count", count, 0);
    check("rst ram_re", ram_re, 0);
    check("rst perr_sticky", perr_sticky, 0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  typedef struct {
    logic              iv;
    logic [DATA_W-1:0] d;
    logic              ordy;
    logic              e_ir;
    logic              e_we;
    logic              e_re;
    logic              e_ov;
    logic [DATA_W-1:0] e_od;
    logic [ADDR_W:0]   e_cnt;
  } vec_t;

  vec_t vecs [NVEC];

  int acc, got, nxt, sent, model_cnt;
  logic prev_stall;
  logic [DATA_W-1:0] prev_data;

  initial begin
    // single push 0xA5, out_ready high: head valid in cycle 2*RD_LAT+1
    vecs[0]  = '{1'b1, 32'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,  5'd0};
    vecs[1]  = '{1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,  5'd1};
    vecs[2]  = '{1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,  5'd1};
    vecs[3]  = '{1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,  5'd1};
    vecs[4]  = '{1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,  5'd1};
    vecs[5]  = '{1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'hA5, 5'd1};
    vecs[6]  = '{1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,  5'd0};
    // two pushes, consumer stalled then released
    vecs[7]  = '{1'b1, 32'h11, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,  5'd0};
    vecs[8]  = '{1'b1, 32'h22, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,  5'd1};
    vecs[9]  = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,  5'd2};
    vecs[10] = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,  5'd2};
    vecs[11] = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,  5'd2};
    vecs[12] = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h11, 5'd2};
    vecs[13] = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h11, 5'd2};
    vecs[14] = '{1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h11, 5'd2};
    vecs[15] = '{1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h22, 5'd1};
    vecs[16] = '{1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,  5'd0};

    do_reset();
    for (int i = 0; i < NVEC; i++) begin
      bus.in_valid  = vecs[i].iv;
      bus.in_data   = vecs[i].d;
      bus.out_ready = vecs[i].ordy;
      @(negedge clk);
      check($sformatf("vec%0d in_ready", i), bus.in_ready, vecs[i].e_ir);
      check($sformatf("vec%0d ram_we", i), ram_we, vecs[i].e_we);
      check($sformatf("vec%0d ram_re", i), ram_re, vecs[i].e_re);
      check($sformatf("vec%0d out_valid", i), bus.out_valid, vecs[i].e_ov);
      check($sformatf("vec%0d count", i), count, vecs[i].e_cnt);
      if (vecs[i].e_ov) check($sformatf("vec%0d out_data", i), bus.out_data, vecs[i].e_od);
      @(posedge clk); #1;
    end

    // fill with consumer stalled: RAM plus output buffer hold MAXCNT words
    do_reset();
    acc = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 32'h100 + acc;
      @(negedge clk);
      if (!bus.in_ready) break;
      acc++;
      @(posedge clk); #1;
    end
    check("fill accepted", acc, MAXCNT);
    check("fill count", count, MAXCNT);
    check("fill ram_we blocked", ram_we, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("fill still blocked", bus.in_ready, 0);
    check("fill count held", count, MAXCNT);
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    got = 0;
    for (int cyc = 0; cyc < 200 && got < MAXCNT; cyc++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        check("fill order", bus.out_data, 32'h100 + got);
        got++;
      end
      @(posedge clk); #1;
    end
    check("fill drained words", got, MAXCNT);
    @(negedge clk);
    check("fill drained count", count, 0);
    check("fill in_ready back", bus.in_ready, 1);

    // continuous streaming: no gaps, constant count once primed
    do_reset();
    bus.out_ready = 1'b1;
    nxt = 0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 32'h1000 + cyc;
      @(negedge clk);
      check("stream in_ready", bus.in_ready, 1);
      if (cyc >= 2 * RD_LAT + 1) begin
        check("stream out_valid", bus.out_valid, 1);
        check("stream order", bus.out_data, 32'h1000 + nxt);
        check("stream count", count, 2 * RD_LAT + 1);
      end else begin
        check("stream prime out_valid", bus.out_valid, 0);
      end
      if (bus.out_valid) nxt++;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    for (int cyc = 0; cyc < 50 && nxt < 100; cyc++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        check("stream tail order", bus.out_data, 32'h1000 + nxt);
        nxt++;
      end
      @(posedge clk); #1;
    end
    check("stream words", nxt, 100);
    @(negedge clk);
    check("stream final count", count, 0);
    @(posedge clk); #1;

    // random backpressure with pointer wrap
    do_reset();
    sent = 0; nxt = 0; model_cnt = 0; prev_stall = 1'b0; prev_data = '0;
    for (int cyc = 0; cyc < 800 && nxt < 40; cyc++) begin
      bus.in_valid  = (sent < 40);
      bus.in_data   = 32'h2000 + sent;
      bus.out_ready = ($urandom_range(0, 1) == 1);
      @(negedge clk);
      if (prev_stall) begin
        check("bp stall valid", bus.out_valid, 1);
        check("bp stall data", bus.out_data, prev_data);
      end
      check("bp count", count, model_cnt);
      if (bus.in_valid && bus.in_ready) begin
        sent++;
        model_cnt++;
      end
      if (bus.out_valid && bus.out_ready) begin
        check("bp order", bus.out_data, 32'h2000 + nxt);
        nxt++;
        model_cnt--;
      end
      prev_stall = bus.out_valid & ~bus.out_ready;
      prev_data  = bus.out_data;
      @(posedge clk); #1;
    end
    check("bp words", nxt, 40);

    // parity error on the 3rd returned word
    do_reset();
    perr_target   = 3;
    bus.out_ready = 1'b1;
    nxt = 0;
    for (int cyc = 0; cyc < 60 && nxt < 5; cyc++) begin
      bus.in_valid = (cyc < 5);
      bus.in_data  = 32'h3000 + cyc;
      @(negedge clk);
      if (bus.out_valid) begin
        check("perr data", bus.out_data, 32'h3000 + nxt);
        check("perr sticky at word", perr_sticky, (nxt >= 2));
        nxt++;
      end
      @(posedge clk); #1;
    end
    check("perr words", nxt, 5);
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    @(negedge clk);
    check("perr sticky held", perr_sticky, 1);
    @(posedge clk); #1;
    perr_target = 0;
    do_reset();
    @(negedge clk);
    check("perr cleared by rst", perr_sticky, 0);
    @(posedge clk); #1;

    // reset with two reads in flight
    do_reset();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'h4000;
    @(posedge clk); #1;
    bus.in_data   = 32'h4001;
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.in_data  = '0;
    rst = 1'b1;
    #1;
    check("midrst in_ready", bus.in_ready, 0);
    check("midrst out_valid", bus.out_valid, 0);
    check("midrst ram_we", ram_we, 0);
    check("midrst ram_re", ram_re, 0);
    check("midrst count", count, 0);
    check("midrst perr", perr_sticky, 0);
    check("midrst waddr", ram_waddr, 0);
    check("midrst raddr", ram_raddr, 0);
    #1;
    rst = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("postrst in_ready", bus.in_ready, 1);
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("postrst no stale word", bus.out_valid, 0);
      check("postrst count", count, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
